// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: FSM encoding and default sizing.
package trap_ctrl_pkg;

  // FSM state encoding (state register is one bit wide)
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  // Default sizing: four sources, causes 0..4 need three bits
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_CAUSE_W = 3;

endpackage

// File: rtl/trap_sync.sv
// Two-flop synchroniser for an idle-high asynchronous strobe.
// Also produces single-clock fall/rise pulses of the synchronised level.
module trap_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_n,
  output logic sync_n,
  output logic fall,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two metastability stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_n = s2_q;
  assign fall   = s3_q & ~s2_q;
  assign rise   = ~s3_q & s2_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller for a virtualised Z80: collects trap requests, raises NMI
// while running, and tracks RUN/TRAP mode on M1 falling edges.
// trap_state is the FSM state readback (1 = TRAP).
// Constraint: 2**CAUSE_W must be >= NUM_SRC+1.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int                   NUM_SRC     = DEF_NUM_SRC,
  parameter logic [NUM_SRC-1:0]   STICKY_MASK = NUM_SRC'(1),
  parameter int                   CAUSE_W     = DEF_CAUSE_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               m1_n,
  input  logic [NUM_SRC-1:0] src_n,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               new_isr,
  input  logic               last_isr_untrap,
  input  logic               virtual_enabled,
  input  logic               cause_ack,
  output logic               trap_state,
  output logic               nmi_n,
  output logic               capture_address,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic [NUM_SRC-1:0] sticky_q
);

  logic               m1_sync;
  logic               m1_fall;
  logic               m1_rise;
  logic [NUM_SRC-1:0] src_sync;
  logic [NUM_SRC-1:0] src_fall;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] lvl_q;
  logic [NUM_SRC-1:0] sticky_d;
  logic [NUM_SRC-1:0] req;
  logic               trap_pending;
  logic [CAUSE_W-1:0] win_cause;
  logic [0:0]         state_q;
  logic               cap_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               unused_sync;

  trap_sync u_m1_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_n (m1_n),
    .sync_n  (m1_sync),
    .fall    (m1_fall),
    .rise    (m1_rise)
  );

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_sync
    trap_sync u_src_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_n (src_n[g]),
      .sync_n  (src_sync[g]),
      .fall    (src_fall[g]),
      .rise    (src_rise[g])
    );
  end

  assign unused_sync = &{1'b0, m1_sync, src_rise};

  assign trap_state = (state_q == ST_TRAP);

  // Level sources are only sampled at the end of an M1 cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= '1;
    end else if (m1_rise) begin
      lvl_q <= src_sync;
    end
  end

  // Sticky next value: ack clears the latched cause's bit, a new edge overrides
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (STICKY_MASK[i]) begin
        if (cause_ack && (cause_q == CAUSE_W'(i + 1))) sticky_d[i] = 1'b0;
        if (src_fall[i]) sticky_d[i] = ~trap_state;
      end else begin
        sticky_d[i] = 1'b0;
      end
    end
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Per-source requests (enable only gates the request, not the flags)
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = src_en[i] & (STICKY_MASK[i] ? sticky_q[i] : ~lvl_q[i]);
    end
  end

  assign trap_pending = |req;

  // Priority encoder: lowest-index request wins, cause is index+1
  always_comb begin
    win_cause = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_cause = CAUSE_W'(i + 1);
    end
  end

  // RUN/TRAP FSM, capture flag and latched cause; all moves on M1 fall only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_TRAP;
      cap_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      if (cause_ack) cause_q <= '0;
      if (m1_fall) begin
        // cap_q is only ever set when leaving RUN, so it is already 1 only
        // on the following fall, which is where it is cleared
        if (cap_q) cap_q <= 1'b0;
        case (state_q)
          ST_RUN: begin
            if (trap_pending && new_isr) begin
              state_q <= ST_TRAP;
              cap_q   <= 1'b1;
              cause_q <= win_cause;
            end else if (!virtual_enabled) begin
              state_q <= ST_TRAP;
              cause_q <= '0;
            end
          end
          default: begin
            if (last_isr_untrap && virtual_enabled) state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign trap_cause      = cause_q;
  assign nmi_n           = ~(trap_pending & ~trap_state);
  assign capture_address = cap_q | (last_isr_untrap & trap_state & virtual_enabled);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

  logic       clk;
  logic       reset_n;
  logic       m1_n;
  logic [3:0] src_n;
  logic [3:0] src_en;
  logic       new_isr;
  logic       last_isr_untrap;
  logic       virtual_enabled;
  logic       cause_ack;
  logic       trap_state;
  logic       nmi_n;
  logic       capture_address;
  logic [2:0] trap_cause;
  logic [3:0] sticky_q;

  int n_checks = 0;
  int n_pass   = 0;

  trap_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m1_n            (m1_n),
    .src_n           (src_n),
    .src_en          (src_en),
    .new_isr         (new_isr),
    .last_isr_untrap (last_isr_untrap),
    .virtual_enabled (virtual_enabled),
    .cause_ack       (cause_ack),
    .trap_state      (trap_state),
    .nmi_n           (nmi_n),
    .capture_address (capture_address),
    .trap_cause      (trap_cause),
    .sticky_q        (sticky_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks: each half of an M1 cycle lasts long enough to synchronise
  task automatic m1_low();
    m1_n = 1'b0;
    tick(4);
  endtask

  task automatic m1_high();
    m1_n = 1'b1;
    tick(4);
  endtask

  task automatic untrap_cycle();
    virtual_enabled = 1'b1;
    last_isr_untrap = 1'b1;
    m1_low();
    last_isr_untrap = 1'b0;
    m1_high();
  endtask

  task automatic ack_pulse();
    cause_ack = 1'b1;
    tick(1);
    cause_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    m1_n = 1'b1;
    src_n = 4'hf;
    src_en = 4'hf;
    new_isr = 1'b0;
    last_isr_untrap = 1'b0;
    virtual_enabled = 1'b0;
    cause_ack = 1'b0;
    tick(3);
    check("rst_state", trap_state, 1);
    check("rst_nmi", nmi_n, 1);
    check("rst_cap", capture_address, 0);
    check("rst_cause", trap_cause, 0);
    check("rst_sticky", sticky_q, 0);
    reset_n = 1'b1;
    tick(2);

    // leave TRAP via untrap jump: capture is combinational
    virtual_enabled = 1'b1;
    last_isr_untrap = 1'b1;
    #1;
    check("untrap_cap_comb", capture_address, 1);
    m1_low();
    check("untrap_state", trap_state, 0);
    check("run_cap", capture_address, 0);
    last_isr_untrap = 1'b0;
    m1_high();
    check("run_nmi_idle", nmi_n, 1);

    // virtualization off: forced trap, no cause, no capture, no NMI
    virtual_enabled = 1'b0;
    m1_low();
    check("forced_state", trap_state, 1);
    check("forced_cause", trap_cause, 0);
    check("forced_cap", capture_address, 0);
    check("forced_nmi", nmi_n, 1);
    m1_high();
    check("forced_cap2", capture_address, 0);

    // sticky source 0 trap
    untrap_cycle();
    check("run2_state", trap_state, 0);
    src_n = 4'b1110;
    tick(3);
    check("s0_sticky", sticky_q, 4'b0001);
    check("s0_nmi", nmi_n, 0);
    src_n = 4'hf;
    new_isr = 1'b1;
    m1_low();
    new_isr = 1'b0;
    check("s0_state", trap_state, 1);
    check("s0_cause", trap_cause, 1);
    check("s0_cap_a", capture_address, 1);
    check("s0_nmi_trap", nmi_n, 1);
    m1_high();
    check("s0_cap_b", capture_address, 1);
    m1_low();
    check("s0_cap_clr", capture_address, 0);
    check("s0_hold", trap_state, 1);
    m1_high();
    ack_pulse();
    check("ack_cause", trap_cause, 0);
    check("ack_sticky", sticky_q, 0);

    // level sources 2 and 3: sampled on M1 rise, lowest index wins
    untrap_cycle();
    check("run3_nmi", nmi_n, 1);
    src_n = 4'b0011;
    tick(3);
    check("lvl_not_sampled", nmi_n, 1);
    m1_low();
    check("lvl_no_isr_stay", trap_state, 0);
    m1_high();
    check("lvl_nmi", nmi_n, 0);
    new_isr = 1'b1;
    m1_low();
    new_isr = 1'b0;
    check("lvl_cause", trap_cause, 3);
    check("lvl_state", trap_state, 1);
    src_n = 4'hf;
    m1_high();
    m1_low();
    m1_high();
    ack_pulse();
    check("lvl_ack", trap_cause, 0);

    // masked sticky source still latches, only NMI is gated
    untrap_cycle();
    src_en = 4'b1110;
    src_n = 4'b1110;
    tick(3);
    check("mask_sticky", sticky_q, 4'b0001);
    check("mask_nmi", nmi_n, 1);
    src_en = 4'hf;
    #1;
    check("unmask_nmi", nmi_n, 0);
    src_n = 4'hf;

    // latch cause 1, return to RUN, then ack collides with a new edge
    new_isr = 1'b1;
    m1_low();
    new_isr = 1'b0;
    m1_high();
    check("c1_cause", trap_cause, 1);
    untrap_cycle();
    check("c1_run", trap_state, 0);
    check("c1_keep", trap_cause, 1);
    src_n = 4'b1110;
    tick(2);
    ack_pulse();
    check("coll_cause", trap_cause, 0);
    check("coll_sticky", sticky_q, 4'b0001);
    src_n = 4'hf;
    tick(3);

    // edge while trapped clears the sticky bit
    virtual_enabled = 1'b0;
    m1_low();
    m1_high();
    check("t_state", trap_state, 1);
    src_n = 4'b1110;
    tick(3);
    check("t_sticky_clr", sticky_q, 0);
    src_n = 4'hf;

    // reset mid-trap: cause discarded, no NMI
    new_isr = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", trap_state, 1);
    check("mid_rst_nmi", nmi_n, 1);
    check("mid_rst_cause", trap_cause, 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4: number of trap request sources, 1..8.
REQ-002 Parameter STICKY_MASK, default 4'b0001: bit i=1 makes source i edge-latched (I/O-violation type); bit i=0 makes it level-sampled (interrupt type).
REQ-003 Parameter CAUSE_W, default 3: trap_cause width; SHALL satisfy 2^CAUSE_W >= NUM_SRC+1.
REQ-004 Port clk  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Port m1_n  in  1  Z80 M1 strobe, asynchronous to clk.
REQ-007 Port src_n  in  NUM_SRC  trap requests, active-low, asynchronous to clk.
REQ-008 Port src_en  in  NUM_SRC  per-source enable; 0 masks the source from trap_pending.
REQ-009 Port new_isr  in  1  current fetch is the NMI vector entry.
REQ-010 Port last_isr_untrap  in  1  last instruction was the untrap jump.
REQ-011 Port virtual_enabled  in  1  virtualization on.
REQ-012 Port cause_ack  in  1  one-clk pulse; clears latched cause and sticky bits.
REQ-013 Port trap_state  out  1  1 = trap (supervisor) mode.
REQ-014 Port nmi_n  out  1  NMI request to CPU, active-low.
REQ-015 Port capture_address  out  1  address-capture enable.
REQ-016 Port trap_cause  out  CAUSE_W  index of winning source +1; 0 = forced/none.
REQ-017 Port sticky_q  out  NUM_SRC  current sticky flags (status readback).

Function
REQ-018 m1_n and src_n SHALL pass through 2-flop synchronisers; m1_fall and m1_rise SHALL be single-clk pulses from the synchronised m1_n.
REQ-019 Level source i SHALL be sampled into lvl_q[i] on m1_rise only.
REQ-020 Sticky source i SHALL set sticky_q[i] on a synchronised falling edge of src_n[i] while trap_state=0, and clear it on such an edge while trap_state=1.
REQ-021 req[i] = src_en[i] & (STICKY_MASK[i] ? sticky_q[i] : !lvl_q[i]); trap_pending = OR(req).
REQ-022 nmi_n SHALL be combinational: 0 iff trap_pending=1 and trap_state=0.
REQ-023 FSM states RUN (trap_state=0) and TRAP (trap_state=1); transitions SHALL be evaluated only on m1_fall.
REQ-024 RUN->TRAP when virtual_enabled=0 (trap_cause:=0, no capture).
REQ-025 RUN->TRAP when trap_pending=1 and new_isr=1: cap_q:=1, trap_cause:=lowest-index set req bit +1; this rule SHALL take precedence over REQ-024 when both hold.
REQ-026 TRAP->RUN when last_isr_untrap=1 and virtual_enabled=1; otherwise TRAP holds.
REQ-027 cap_q SHALL clear on the m1_fall following the one that set it; a set and a clear SHALL never coincide.
REQ-028 capture_address = cap_q | (last_isr_untrap & trap_state & virtual_enabled).
REQ-029 cause_ack SHALL zero trap_cause and the sticky_q bit of the currently latched cause; if a sticky set edge arrives in the same clk, the set SHALL win.
REQ-030 Masked sources SHALL still update sticky_q/lvl_q; only trap_pending ignores them.

Reset
REQ-031 reset_n=0 SHALL asynchronously force: state=TRAP, cap_q=0, trap_cause=0, sticky_q=0, lvl_q=all 1, synchronisers=1 (idle high).
REQ-032 After reset: nmi_n=1, capture_address=0 until a legal transition; a reset mid-trap SHALL discard the cause without emitting NMI.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (RUN=0, TRAP=1) and the default NUM_SRC/CAUSE_W constants.
REQ-034 One sub-module, trap_sync (2-flop synchroniser with fall/rise pulse outputs), SHALL be instanced for m1_n and for each src_n bit.
REQ-035 Priority encoder and FSM SHALL remain in trap_ctrl.

Verification
REQ-036 Reset, virtual_enabled=0, one M1 -> trap_state=1, trap_cause=0, nmi_n=1, capture_address=0 throughout.
REQ-037 RUN, src_n[0] falls -> sticky_q=4'b0001, nmi_n=0 within 3 clk; next M1 with new_isr=1 -> trap_state=1, trap_cause=1, capture_address=1 for exactly one M1 period.
REQ-038 RUN, src_n[2]=0 and src_n[3]=0 held, then M1 rise -> nmi_n=0; M1 fall with new_isr=1 -> trap_cause=3.
REQ-039 TRAP, last_isr_untrap=1, virtual_enabled=1 -> capture_address=1 combinationally, trap_state=0 after m1_fall+1 clk.
REQ-040 src_en=4'b1110 with src_n[0] edge -> sticky_q[0]=1, nmi_n stays 1; re-enable src_en[0] -> nmi_n=0.
REQ-041 cause_ack coincident with a new src_n[0] fall in RUN -> trap_cause=0, sticky_q[0]=1.
